// File: rtl/fifo_reader_pkg.sv
// Shared definitions for the FIFO read-side controller: FSM encodings and default sizing.
package fifo_reader_pkg;

    localparam int STATE_W        = 2;
    localparam int DEF_BITNUMBER  = 8;
    localparam int DEF_RD_LATENCY = 2;
    localparam int DEF_SKID_DEPTH = 4;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } state_t;

endpackage

// File: rtl/fifo_reader_skid.sv
// Circular skid buffer that absorbs words returned by the FIFO read pipeline.
module fifo_reader_skid
    import fifo_reader_pkg::*;
#(
    parameter int BITNUMBER  = DEF_BITNUMBER,
    parameter int SKID_DEPTH = DEF_SKID_DEPTH,
    localparam int PTR_W     = $clog2(SKID_DEPTH),
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [BITNUMBER-1:0] push_data,
    input  logic                 pop,
    output logic [BITNUMBER-1:0] head_data,
    output logic [CNT_W-1:0]     count
);

    logic [BITNUMBER-1:0] mem [SKID_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Push and pop together leave the occupancy unchanged.
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fifo_reader.sv
// Drains the FIFO with credit-limited pops and presents returned words on a valid/ready stream.
// Optional FIFO_READER_STATS_EN adds words_out / stall_cycles counters.
//
// state | meaning
// IDLE  | no activity; waits for enable with a non-empty FIFO
// RUN   | issuing pops while credit, empty and last-word rules allow
// HOLD  | credit exhausted; waits for the skid buffer to drain
// FLUSH | enable dropped; no pops, waits for in-flight and buffered words to leave
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int BITNUMBER  = DEF_BITNUMBER,
    parameter int RD_LATENCY = DEF_RD_LATENCY,
    parameter int SKID_DEPTH = DEF_SKID_DEPTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 fifo_empty,
    input  logic                 fifo_almost_empty,
    input  logic                 fifo_rd_error,
    input  logic [BITNUMBER-1:0] fifo_data,
    output logic                 fifo_rd,
    output logic [BITNUMBER-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 rd_err
`ifdef FIFO_READER_STATS_EN
    ,
    output logic [15:0]          words_out,
    output logic [15:0]          stall_cycles
`endif
);

    localparam int CNT_W = $clog2(SKID_DEPTH) + 1;
    localparam int SUM_W = CNT_W + 2;

    state_t                state;
    logic [RD_LATENCY-1:0] in_flight;
    logic [CNT_W-1:0]      skid_count;
    logic [SUM_W-1:0]      outstanding;
    logic                  capture;
    logic                  pop;
    logic                  credit_ok;
    logic                  can_issue;
    logic                  drained;

    assign capture   = in_flight[RD_LATENCY-1];
    assign out_valid = (skid_count != '0);
    assign pop       = out_valid & out_ready;
    assign busy      = (state != IDLE) || (in_flight != '0);

    // Words already owed to the buffer, counting the pop on the wire now and
    // releasing the slot handed downstream this cycle, so a steady stream needs no bubble.
    always_comb begin
        outstanding = SUM_W'(skid_count) + SUM_W'($countones(in_flight))
                    + SUM_W'(fifo_rd) - SUM_W'(pop);
        credit_ok   = outstanding < SUM_W'(SKID_DEPTH);
        can_issue   = enable && credit_ok && !fifo_empty
                    && !(fifo_almost_empty && fifo_rd);
        drained     = (in_flight == '0) && (skid_count == '0) && !fifo_rd;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            fifo_rd   <= 1'b0;
            in_flight <= '0;
            rd_err    <= 1'b0;
        end else begin
            in_flight <= (in_flight << 1) | RD_LATENCY'(fifo_rd);
            if (fifo_rd_error) begin
                rd_err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    fifo_rd <= 1'b0;
                    if (enable && !fifo_empty) begin
                        state   <= RUN;
                        fifo_rd <= can_issue;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state   <= FLUSH;
                        fifo_rd <= 1'b0;
                    end else if (fifo_empty && drained) begin
                        state   <= IDLE;
                        fifo_rd <= 1'b0;
                    end else if (!credit_ok) begin
                        state   <= HOLD;
                        fifo_rd <= 1'b0;
                    end else begin
                        fifo_rd <= can_issue;
                    end
                end
                HOLD: begin
                    fifo_rd <= 1'b0;
                    if (!enable) begin
                        state <= FLUSH;
                    end else if (credit_ok) begin
                        state   <= RUN;
                        fifo_rd <= can_issue;
                    end
                end
                FLUSH: begin
                    fifo_rd <= 1'b0;
                    if (drained) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    fifo_rd <= 1'b0;
                end
            endcase
        end
    end

    fifo_reader_skid #(
        .BITNUMBER  (BITNUMBER),
        .SKID_DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (capture),
        .push_data (fifo_data),
        .pop       (pop),
        .head_data (out_data),
        .count     (skid_count)
    );

`ifdef FIFO_READER_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            words_out    <= '0;
            stall_cycles <= '0;
        end else begin
            if (pop) begin
                words_out <= words_out + 1'b1;
            end
            if (out_valid && !out_ready && (stall_cycles != 16'hFFFF)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader: behavioural FIFO with 2-edge read latency plus stream monitor.
module tb_fifo_reader;
    import fifo_reader_pkg::*;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       fifo_empty;
    logic       fifo_almost_empty;
    logic       fifo_rd_error;
    logic [7:0] fifo_data;
    logic       fifo_rd;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       rd_err;
`ifdef FIFO_READER_STATS_EN
    logic [15:0] words_out;
    logic [15:0] stall_cycles;
`endif

    fifo_reader #(.BITNUMBER(8), .RD_LATENCY(2), .SKID_DEPTH(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .enable            (enable),
        .fifo_empty        (fifo_empty),
        .fifo_almost_empty (fifo_almost_empty),
        .fifo_rd_error     (fifo_rd_error),
        .fifo_data         (fifo_data),
        .fifo_rd           (fifo_rd),
        .out_data          (out_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .busy              (busy),
        .rd_err            (rd_err)
`ifdef FIFO_READER_STATS_EN
        ,
        .words_out         (words_out),
        .stall_cycles      (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural FIFO: fifo_data holds the popped word two edges after the pop is sampled.
    logic [7:0] fmem [16];
    logic [7:0] fpipe;
    int         fptr = 0;
    int         fcnt = 0;
    int         underflow = 0;
    logic       load_req;
    int         load_n;
    logic [7:0] load_base;

    assign fifo_empty        = (fcnt == 0);
    assign fifo_almost_empty = (fcnt == 1);

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 16; i++) begin
                fmem[i] <= load_base + 8'(i);
            end
            fptr <= 0;
            fcnt <= load_n;
        end else if (fifo_rd) begin
            if (fcnt == 0) begin
                underflow <= underflow + 1;
            end else begin
                fpipe <= fmem[fptr];
                fptr  <= fptr + 1;
                fcnt  <= fcnt - 1;
            end
        end
        fifo_data <= fpipe;
    end

    // Stream monitor
    logic [7:0] got [$];
    int rd_pulses = 0;
    int stall_mon = 0;
    int cyc = 0;
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!reset) begin
            if (fifo_rd) rd_pulses = rd_pulses + 1;
            if (out_valid && out_ready) got.push_back(out_data);
            if (out_valid && !out_ready) stall_mon = stall_mon + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load_fifo(input int n, input logic [7:0] base);
        @(negedge clk);
        load_n    = n;
        load_base = base;
        load_req  = 1'b1;
        @(negedge clk);
        load_req  = 1'b0;
    endtask

    logic saw_flush;
    task automatic wait_idle(input string tag, input int target, input int bound);
        bit ok = 0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (dut.state == FLUSH) saw_flush = 1'b1;
            if (got.size() >= target && !busy && !out_valid) begin
                ok = 1;
                break;
            end
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    initial begin
        int gi;
        int p0;
        int first_rd;
        int first_v;
        bit ok;

        reset = 1'b1; enable = 1'b0; out_ready = 1'b0; fifo_rd_error = 1'b0;
        load_req = 1'b0; load_n = 0; load_base = 8'h00; saw_flush = 1'b0;
        gi = 0;
        repeat (2) @(negedge clk);
        check("rst_fifo_rd",   32'(fifo_rd),   32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_rd_err",    32'(rd_err),    32'd0);
        reset = 1'b0;

        // Stream 0x11..0x18 with downstream always ready
        load_fifo(8, 8'h11);
        out_ready = 1'b1;
        enable = 1'b1;
        p0 = rd_pulses; first_rd = -1; first_v = -1; ok = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (fifo_rd && first_rd < 0) first_rd = cyc;
            if (out_valid && first_v < 0) first_v = cyc;
            if (got.size() >= gi + 8 && !busy && !out_valid) begin
                ok = 1;
                break;
            end
        end
        check("stream_done", 32'(ok), 32'd1);
        check("stream_latency", 32'(first_v - first_rd), 32'd3);
        for (int k = 0; k < 8; k++) begin
            check("stream_word", 32'(got[gi]), 32'h11 + 32'(k));
            gi++;
        end
        check("stream_pulses", 32'(rd_pulses - p0), 32'd8);
        check("stream_underflow", 32'(underflow), 32'd0);
        check("stream_busy", 32'(busy), 32'd0);
        check("stream_rd_err", 32'(rd_err), 32'd0);
        enable = 1'b0;

        // Single word in FIFO
        load_fifo(1, 8'h5A);
        p0 = rd_pulses;
        enable = 1'b1;
        wait_idle("single_done", gi + 1, 50);
        check("single_word", 32'(got[gi]), 32'h5A);
        gi++;
        check("single_pulses", 32'(rd_pulses - p0), 32'd1);
        check("single_busy", 32'(busy), 32'd0);
        check("single_idle", 32'(dut.state), 32'(IDLE));
        enable = 1'b0;

        // Backpressure: only SKID_DEPTH words may leave the FIFO
        load_fifo(8, 8'h21);
        out_ready = 1'b0;
        p0 = rd_pulses;
        enable = 1'b1;
        repeat (30) @(negedge clk);
        check("bp_pulses", 32'(rd_pulses - p0), 32'd4);
        check("bp_fifo_rd", 32'(fifo_rd), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_out_data", 32'(out_data), 32'h21);
        out_ready = 1'b1;
        wait_idle("bp_done", gi + 8, 100);
        for (int k = 0; k < 8; k++) begin
            check("bp_word", 32'(got[gi]), 32'h21 + 32'(k));
            gi++;
        end
        check("bp_pulses_total", 32'(rd_pulses - p0), 32'd8);
        check("bp_underflow", 32'(underflow), 32'd0);
        enable = 1'b0;

        // Enable dropped after two pops issued
        load_fifo(8, 8'h31);
        p0 = rd_pulses;
        saw_flush = 1'b0;
        enable = 1'b1;
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (dut.state == FLUSH) saw_flush = 1'b1;
            if (rd_pulses - p0 + int'(fifo_rd) == 2) begin
                ok = 1;
                break;
            end
        end
        check("drop_two_pops", 32'(ok), 32'd1);
        enable = 1'b0;
        wait_idle("drop_done", gi + 2, 50);
        check("drop_pulses", 32'(rd_pulses - p0), 32'd2);
        check("drop_word0", 32'(got[gi]), 32'h31);
        check("drop_word1", 32'(got[gi + 1]), 32'h32);
        gi += 2;
        check("drop_saw_flush", 32'(saw_flush), 32'd1);
        check("drop_idle", 32'(dut.state), 32'(IDLE));

        // Sticky read error
        @(negedge clk);
        fifo_rd_error = 1'b1;
        @(negedge clk);
        fifo_rd_error = 1'b0;
        check("err_set", 32'(rd_err), 32'd1);
        load_fifo(2, 8'h41);
        enable = 1'b1;
        wait_idle("err_done", gi + 2, 50);
        check("err_word0", 32'(got[gi]), 32'h41);
        check("err_word1", 32'(got[gi + 1]), 32'h42);
        gi += 2;
        check("err_held", 32'(rd_err), 32'd1);
`ifdef FIFO_READER_STATS_EN
        check("stats_words_out", 32'(words_out), 32'd21);
        check("stats_stall", 32'(stall_cycles), 32'(stall_mon));
`endif
        enable = 1'b0;

        // Reset while three reads are outstanding
        load_fifo(8, 8'h51);
        out_ready = 1'b0;
        p0 = rd_pulses;
        enable = 1'b1;
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rd_pulses - p0 == 2 && fifo_rd) begin
                ok = 1;
                break;
            end
        end
        check("mid_three_inflight", 32'(ok), 32'd1);
        reset = 1'b1;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_fifo_rd",   32'(fifo_rd),   32'd0);
        check("mid_out_valid", 32'(out_valid), 32'd0);
        check("mid_out_data",  32'(out_data),  32'd0);
        check("mid_busy",      32'(busy),      32'd0);
        check("mid_rd_err",    32'(rd_err),    32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_fifo_rd", 32'(fifo_rd), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
`ifdef FIFO_READER_STATS_EN
        check("post_rst_words_out", 32'(words_out), 32'd0);
        check("post_rst_stall", 32'(stall_cycles), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
